// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: configurable-frame UART transmitter fed by a small FIFO.
// Frame format (data length, parity mode, stop bits) is sampled when a frame
// starts, so the configuration may change freely while a frame is on the line.
// Bit timing follows the external BAUD strobe; one bit per strobe period.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BAUD,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [3:0]        CFG_LEN,
  input  logic [2:0]        CFG_PAR,
  input  logic              CFG_STOP,
  output logic              TX,
  output logic              BUSY,
  output logic              TX_DONE,
  output logic [LVL_W-1:0]  FIFO_LEVEL
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [3:0]      MAX_LEN  = 4'(DATA_W);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head_q;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_next;
  logic [LVL_W-1:0]  level_reg;
  logic [LVL_W-1:0]  level_next;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full       = (level_reg == FULL_LVL);
  assign empty      = (level_reg == '0);
  assign IN_READY   = !full;
  assign push       = IN_VALID && !full;
  assign FIFO_LEVEL = level_reg;

  // Occupancy and read-address lookahead; a push while full is refused even
  // if the same edge pops.
  always_comb begin
    level_next  = level_reg;
    rd_ptr_next = rd_ptr_reg;
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Storage with registered head read; a write landing on the next head
  // address is forwarded so a word pushed into an empty FIFO is ready one
  // clock later.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= IN_DATA;
    end
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_q <= IN_DATA;
    end else begin
      head_q <= mem[rd_ptr_next];
    end
  end

  // Pointer and level registers; pointers wrap naturally since DEPTH is a
  // power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration decode for the frame about to start
  // ---------------------------------------------------------------------------
  logic [3:0] len_eff;
  logic       data_xor;
  logic       par_en_new;
  logic       par_val_new;

  // Resolve length and parity from the live config and the FIFO head.
  always_comb begin
    len_eff = ((CFG_LEN >= 4'd5) && (CFG_LEN <= MAX_LEN)) ? CFG_LEN : MAX_LEN;
    data_xor = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < len_eff) begin
        data_xor = data_xor ^ head_q[i];
      end
    end
    par_en_new  = 1'b0;
    par_val_new = 1'b0;
    case (CFG_PAR)
      3'b001:  begin par_en_new = 1'b1; par_val_new = data_xor;  end
      3'b010:  begin par_en_new = 1'b1; par_val_new = !data_xor; end
      3'b011:  begin par_en_new = 1'b1; par_val_new = 1'b1;      end
      3'b100:  begin par_en_new = 1'b1; par_val_new = 1'b0;      end
      default: begin par_en_new = 1'b0; par_val_new = 1'b0;      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t            state_reg,   state_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg,   shift_next;
  logic [3:0]        len_reg,     len_next;
  logic              par_en_reg,  par_en_next;
  logic              par_val_reg, par_val_next;
  logic              stop2_reg,   stop2_next;
  logic              tx_reg,      tx_next;
  logic              done_reg,    done_next;
  logic              busy_reg,    busy_next;
  logic              frame_end;
  logic              start_frame;

  // Next-state and next-output logic; every move is gated by BAUD.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    len_next     = len_reg;
    par_en_next  = par_en_reg;
    par_val_next = par_val_reg;
    stop2_next   = stop2_reg;
    tx_next      = tx_reg;
    done_next    = 1'b0;
    frame_end    = 1'b0;
    start_frame  = 1'b0;
    pop          = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (BAUD && !empty) begin
          start_frame = 1'b1;
        end
      end
      START: begin
        if (BAUD) begin
          state_next   = DATA;
          tx_next      = shift_reg[0];
          bit_cnt_next = 4'd0;
        end
      end
      DATA: begin
        if (BAUD) begin
          if (bit_cnt_reg == (len_reg - 4'd1)) begin
            if (par_en_reg) begin
              state_next = PARITY;
              tx_next    = par_val_reg;
            end else begin
              state_next = STOP1;
              tx_next    = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            tx_next      = shift_reg[1];
            shift_next   = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (BAUD) begin
          state_next = STOP1;
          tx_next    = 1'b1;
        end
      end
      STOP1: begin
        if (BAUD) begin
          if (stop2_reg) begin
            state_next = STOP2;
            tx_next    = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      STOP2: begin
        if (BAUD) begin
          frame_end = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // End of frame: either chain straight into the next start bit or go idle.
    if (frame_end) begin
      done_next = 1'b1;
      if (!empty) begin
        start_frame = 1'b1;
      end else begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    end

    // Frame start: pop the head and freeze the frame format.
    if (start_frame) begin
      pop          = 1'b1;
      state_next   = START;
      tx_next      = 1'b0;
      shift_next   = head_q;
      len_next     = len_eff;
      par_en_next  = par_en_new;
      par_val_next = par_val_new;
      stop2_next   = CFG_STOP;
    end
  end

  // Busy whenever a frame is on the line or words are waiting.
  always_comb begin
    busy_next = (state_next != IDLE) || (level_next != '0);
  end

  // FSM and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      len_reg     <= MAX_LEN;
      par_en_reg  <= 1'b0;
      par_val_reg <= 1'b0;
      stop2_reg   <= 1'b0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      len_reg     <= len_next;
      par_en_reg  <= par_en_next;
      par_val_reg <= par_val_next;
      stop2_reg   <= stop2_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  assign TX      = tx_reg;
  assign TX_DONE = done_reg;
  assign BUSY    = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. Stimulus queues the
// expected serial frame for every word; a monitor samples TX once per BAUD
// period and checks each completed frame when TX_DONE pulses.
module tb_uart_tx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic              BAUD = 1'b0;
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [3:0]        CFG_LEN;
  logic [2:0]        CFG_PAR;
  logic              CFG_STOP;
  logic              TX;
  logic              BUSY;
  logic              TX_DONE;
  logic [LVL_W-1:0]  FIFO_LEVEL;

  int     checks   = 0;
  int     failures = 0;
  int     frames   = 0;
  int     baud_idx = 0;
  int     bcnt     = 0;
  logic   baud_en  = 1'b1;
  frame_t exp_q[$];
  logic   cur_q[$];
  int     done_idx_q[$];

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BAUD       (BAUD),
    .IN_DATA    (IN_DATA),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .CFG_LEN    (CFG_LEN),
    .CFG_PAR    (CFG_PAR),
    .CFG_STOP   (CFG_STOP),
    .TX         (TX),
    .BUSY       (BUSY),
    .TX_DONE    (TX_DONE),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  // Baud strobe: one clock in four, suppressible for the FIFO fill test.
  always @(negedge CLK) begin
    bcnt = (bcnt == 3) ? 0 : bcnt + 1;
    BAUD = baud_en && (bcnt == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic frame_t add_bit(input frame_t f, input logic b);
    frame_t r = f;
    r.bits[r.n] = b;
    r.n++;
    return r;
  endfunction

  // Frame written out literally, first transmitted bit first.
  function automatic frame_t from_str(input string s);
    frame_t f;
    f.bits = '0;
    f.n    = 0;
    for (int i = 0; i < s.len(); i++) begin
      f = add_bit(f, s[i] == 8'h31);
    end
    return f;
  endfunction

  // Reference frame built from the format rules.
  function automatic frame_t model(input logic [7:0] d, input logic [3:0] len,
                                   input logic [2:0] par, input logic stop);
    frame_t f;
    int     l;
    int     ones;
    f.bits = '0;
    f.n    = 0;
    l      = (len >= 5 && len <= DATA_W) ? int'(len) : DATA_W;
    ones   = 0;
    f = add_bit(f, 1'b0);
    for (int i = 0; i < l; i++) begin
      f = add_bit(f, d[i]);
      ones += int'(d[i]);
    end
    case (par)
      3'd1: f = add_bit(f, (ones % 2) == 1);
      3'd2: f = add_bit(f, (ones % 2) == 0);
      3'd3: f = add_bit(f, 1'b1);
      3'd4: f = add_bit(f, 1'b0);
      default: ;
    endcase
    f = add_bit(f, 1'b1);
    if (stop) f = add_bit(f, 1'b1);
    return f;
  endfunction

  // Monitor: one TX sample per BAUD period; a TX_DONE closes the frame.
  initial begin : monitor
    logic        b;
    logic [15:0] act;
    frame_t      e;
    forever begin
      @(posedge CLK);
      b = BAUD;
      #1;
      if (!RST) begin
        cur_q.delete();
        continue;
      end
      if (TX_DONE && !b) begin
        checks++;
        failures++;
        $display("FAIL done_without_baud actual=1 required=0");
      end
      if (b) begin
        baud_idx++;
        if (TX_DONE) begin
          act = '0;
          for (int i = 0; i < cur_q.size() && i < 16; i++) act[i] = cur_q[i];
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame actual=%b/%0d required=none", act, cur_q.size());
          end else begin
            e = exp_q.pop_front();
            if (e.n != cur_q.size() || e.bits !== act) begin
              failures++;
              $display("FAIL frame%0d actual=%b/%0d required=%b/%0d",
                       frames, act, cur_q.size(), e.bits, e.n);
            end else begin
              $display("frame%0d ok bits=%b n=%0d", frames, act, e.n);
            end
          end
          frames++;
          check("busy_at_done", {31'd0, BUSY}, {31'd0, exp_q.size() > 0});
          done_idx_q.push_back(baud_idx);
          cur_q.delete();
        end
        if (cur_q.size() > 0 || TX == 1'b0) cur_q.push_back(TX);
        if (cur_q.size() > 16) begin
          checks++;
          failures++;
          $display("FAIL frame_overrun actual=%0d required<=16", cur_q.size());
          cur_q.delete();
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [7:0] d, input frame_t e);
    int t = 0;
    exp_q.push_back(e);
    IN_DATA  = d;
    IN_VALID = 1'b1;
    while (!IN_READY && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 5000) check("push_timeout", 32'd1, 32'd0);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge CLK);
    while ((BUSY || exp_q.size() != 0) && t < 20000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 20000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic set_cfg(input logic [3:0] l, input logic [2:0] p, input logic s);
    CFG_LEN  = l;
    CFG_PAR  = p;
    CFG_STOP = s;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] d;
    logic [3:0] l;
    logic [2:0] p;
    logic       s;
    int         t;

    RST      = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    set_cfg(4'd8, 3'd0, 1'b0);
    repeat (3) @(negedge CLK);
    check("rst_tx",       {31'd0, TX},       32'd1);
    check("rst_busy",     {31'd0, BUSY},     32'd0);
    check("rst_done",     {31'd0, TX_DONE},  32'd0);
    check("rst_ready",    {31'd0, IN_READY}, 32'd1);
    check("rst_level",    32'(FIFO_LEVEL),   32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // 8N1 literal frame
    set_cfg(4'd8, 3'd0, 1'b0);
    push_word(8'hA5, from_str("0101001011"));
    check("busy_after_push", {31'd0, BUSY}, 32'd1);
    wait_idle();

    // 7E2; bit 7 set but must not appear
    set_cfg(4'd7, 3'd1, 1'b1);
    push_word(8'h83, from_str("01100000011"));
    wait_idle();

    // 5-bit odd, mark, space
    set_cfg(4'd5, 3'd2, 1'b0);
    push_word(8'h1F, from_str("01111101"));
    wait_idle();
    set_cfg(4'd5, 3'd3, 1'b0);
    push_word(8'h1F, from_str("01111111"));
    wait_idle();
    set_cfg(4'd5, 3'd4, 1'b0);
    push_word(8'h1F, from_str("01111101"));
    wait_idle();

    // Out-of-range lengths fall back to full width
    set_cfg(4'd15, 3'd0, 1'b0);
    push_word(8'h5A, from_str("0010110101"));
    wait_idle();
    set_cfg(4'd3, 3'd1, 1'b0);
    push_word(8'hC6, model(8'hC6, 4'd3, 3'd1, 1'b0));
    wait_idle();

    // Config change mid-frame only affects the following frame
    set_cfg(4'd8, 3'd0, 1'b0);
    push_word(8'h3C, model(8'h3C, 4'd8, 3'd0, 1'b0));
    t = 0;
    while (TX !== 1'b0 && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 1000) check("start_timeout", 32'd1, 32'd0);
    set_cfg(4'd6, 3'd2, 1'b1);
    push_word(8'hE7, model(8'hE7, 4'd6, 3'd2, 1'b1));
    wait_idle();

    // Fill with BAUD stopped, then drain back-to-back
    set_cfg(4'd8, 3'd0, 1'b0);
    baud_en = 1'b0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < DEPTH + 2; i++) begin
      IN_DATA  = 8'($urandom);
      IN_VALID = 1'b1;
      check("fill_ready", {31'd0, IN_READY}, {31'd0, i < DEPTH});
      check("fill_level", 32'(FIFO_LEVEL), (i < DEPTH) ? i : DEPTH);
      if (i < DEPTH) exp_q.push_back(model(IN_DATA, 4'd8, 3'd0, 1'b0));
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    check("full_level", 32'(FIFO_LEVEL), DEPTH);
    done_idx_q.delete();
    baud_en = 1'b1;
    wait_idle();
    check("drain_frames", done_idx_q.size(), DEPTH);
    for (int k = 1; k < done_idx_q.size(); k++) begin
      check("b2b_spacing", done_idx_q[k] - done_idx_q[k-1], 10);
    end

    // Randomized batches, format held per batch
    for (int bt = 0; bt < 6; bt++) begin
      l = 4'($urandom_range(0, 15));
      p = 3'($urandom_range(0, 7));
      s = 1'($urandom_range(0, 1));
      set_cfg(l, p, s);
      for (int w = 0, n = $urandom_range(1, 6); w < n; w++) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        d = 8'($urandom);
        push_word(d, model(d, l, p, s));
      end
      wait_idle();
    end
    check("queue_drained", exp_q.size(), 0);

    // Reset in the middle of a frame
    set_cfg(4'd8, 3'd0, 1'b0);
    push_word(8'h96, model(8'h96, 4'd8, 3'd0, 1'b0));
    push_word(8'h69, model(8'h69, 4'd8, 3'd0, 1'b0));
    push_word(8'hF0, model(8'hF0, 4'd8, 3'd0, 1'b0));
    t = 0;
    while (cur_q.size() < 4 && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 1000) check("data_timeout", 32'd1, 32'd0);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_tx",    {31'd0, TX},   32'd1);
    check("midrst_level", 32'(FIFO_LEVEL), 32'd0);
    check("midrst_busy",  {31'd0, BUSY}, 32'd0);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    t = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (TX !== 1'b1 || TX_DONE !== 1'b0 || BUSY !== 1'b0) t++;
    end
    check("quiet_after_rst", t, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
